// File: rtl/uart_pkg.sv
// Shared types for the UART transmit path: frame state encoding and parity modes.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        PAR,
        STOP
    } tx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: pulses bit_done on the last clk of every serial bit.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || bit_done) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign bit_done = !clear && (cnt == LAST);

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// Drains a synchronous byte FIFO into an asynchronous UART frame on tx.
// tx is registered from the next state so every bit boundary lines up with a clock edge.
module uart_tx_fifo_drain
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy
);

    if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
        $fatal(1, "uart_tx_fifo_drain: DATA_WIDTH must be 5..9");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $fatal(1, "uart_tx_fifo_drain: CLKS_PER_BIT must be >= 2");
    end
    if (PARITY < PAR_NONE || PARITY > PAR_ODD) begin : g_bad_parity
        $fatal(1, "uart_tx_fifo_drain: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $fatal(1, "uart_tx_fifo_drain: STOP_BITS must be 1 or 2");
    end

    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    tx_state_t             state, next_state;
    logic [DATA_WIDTH-1:0] shreg, shreg_d;
    logic [BW-1:0]         bit_cnt;
    logic                  par_bit;
    logic                  tx_d;
    logic                  bit_done;
    logic                  baud_clear;
    logic                  last_data, last_stop;

    assign baud_clear = (state == IDLE) || (state == FETCH) || (state == LOAD);
    assign last_data  = (bit_cnt == LAST_DATA);
    assign last_stop  = (bit_cnt == LAST_STOP);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .clear   (baud_clear),
        .bit_done(bit_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (tx_en && !fifo_empty) next_state = FETCH;
            FETCH:   next_state = LOAD;
            LOAD:    next_state = START;
            START:   if (bit_done) next_state = DATA;
            DATA:    if (bit_done && last_data) next_state = (PARITY != PAR_NONE) ? PAR : STOP;
            PAR:     if (bit_done) next_state = STOP;
            STOP:    if (bit_done && last_stop) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Shift-register next value is shared with the tx decode so tx sees the post-shift bit.
    always_comb begin
        shreg_d = shreg;
        if (state == LOAD) begin
            shreg_d = fifo_dout;
        end else if (state == DATA && bit_done) begin
            shreg_d = shreg >> 1;
        end
    end

    always_comb begin
        fifo_rd_en = (state == FETCH);
        busy       = (state != IDLE);
        case (next_state)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            PAR:     tx_d = par_bit;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
            par_bit <= 1'b0;
            tx      <= 1'b1;
        end else begin
            shreg <= shreg_d;
            tx    <= tx_d;
            case (state)
                LOAD: begin
                    bit_cnt <= '0;
                    par_bit <= (^fifo_dout) ^ (PARITY == PAR_ODD);
                end
                DATA:    if (bit_done) bit_cnt <= last_data ? '0 : bit_cnt + BW'(1);
                STOP:    if (bit_done) bit_cnt <= last_stop ? '0 : bit_cnt + BW'(1);
                default: bit_cnt <= bit_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Directed bench: three transmitter configurations share one FIFO model; only one is enabled at a time.
module tb_uart_tx_fifo_drain;

    localparam int CPB = 4;

    logic       clk;
    logic       rst;
    logic       tx_en0, tx_en1, tx_en2;
    logic       rd0, rd1, rd2;
    logic       tx0, tx1, tx2;
    logic       busy0, busy1, busy2;
    logic       any_rd;
    logic       fifo_empty;
    logic [7:0] fifo_dout;
    logic [7:0] mem [0:31];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    int         cyc = 0;

    logic [1:0] sel;
    logic       cur_tx, cur_busy, cur_rd;

    int         checks = 0;
    int         errors = 0;

    uart_tx_fifo_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .tx_en(tx_en0), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_rd_en(rd0), .tx(tx0), .busy(busy0)
    );

    uart_tx_fifo_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1)) dut_even (
        .clk(clk), .rst(rst), .tx_en(tx_en1), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_rd_en(rd1), .tx(tx1), .busy(busy1)
    );

    uart_tx_fifo_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(2)) dut_odd (
        .clk(clk), .rst(rst), .tx_en(tx_en2), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_rd_en(rd2), .tx(tx2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model with registered read data, valid the cycle after the read strobe.
    assign any_rd     = rd0 | rd1 | rd2;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (any_rd && !fifo_empty) begin
            fifo_dout <= mem[rd_ptr % 32];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    always_comb begin
        case (sel)
            2'd1:    begin cur_tx = tx1; cur_busy = busy1; cur_rd = rd1; end
            2'd2:    begin cur_tx = tx2; cur_busy = busy2; cur_rd = rd2; end
            default: begin cur_tx = tx0; cur_busy = busy0; cur_rd = rd0; end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr_ptr % 32] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_rd(input int limit, output bit found);
        found = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (cur_rd) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    // Starts on the read-strobe cycle; records the first sample of every bit, flags any
    // change within a bit, and optionally drops tx_en0 at a given sample index of the frame.
    task automatic capture(input int nbits, input int drop_at, output logic [15:0] bits,
                           output bit ok, output int busy_cnt, output int rd_cnt);
        bits     = '0;
        ok       = 1'b1;
        busy_cnt = cur_busy ? 1 : 0;
        rd_cnt   = cur_rd ? 1 : 0;
        @(negedge clk);
        if (cur_busy) busy_cnt++;
        if (cur_rd) rd_cnt++;
        if (cur_tx !== 1'b1) ok = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            for (int j = 0; j < CPB; j++) begin
                @(negedge clk);
                if (i * CPB + j == drop_at) tx_en0 = 1'b0;
                if (cur_busy) busy_cnt++;
                if (cur_rd) rd_cnt++;
                if (j == 0) bits[i] = cur_tx;
                else if (cur_tx !== bits[i]) ok = 1'b0;
            end
        end
    endtask

    bit          found, ok, bad;
    logic [15:0] bits;
    int          bc, rc, t1, t2;
    logic [7:0]  drain_word [3];
    logic [15:0] drain_frame [3];

    initial begin
        drain_word  = '{8'h22, 8'h33, 8'h44};
        drain_frame = '{16'h0244, 16'h0266, 16'h0288};
        sel    = 2'd0;
        rst    = 1'b1;
        tx_en0 = 1'b0;
        tx_en1 = 1'b0;
        tx_en2 = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_tx", tx0, 1);
        check("rst_busy", busy0, 0);
        check("rst_rd", rd0, 0);
        rst    = 1'b0;
        tx_en0 = 1'b1;
        bad    = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (!tx0 || busy0 || any_rd) bad = 1'b1;
        end
        check("idle_after_rst", bad, 0);

        // single word 0xA5, 8N1
        push(8'hA5);
        wait_rd(20, found);
        check("a5_rd_seen", found, 1);
        capture(10, -1, bits, ok, bc, rc);
        check("a5_frame", bits, 16'h034A);
        check("a5_bit_hold", ok, 1);
        check("a5_rd_count", rc, 1);
        check("a5_busy_cycles", bc, 42);
        @(negedge clk);
        check("a5_busy_end", busy0, 0);

        // back-to-back 0x00 then 0xFF
        push(8'h00);
        push(8'hFF);
        wait_rd(20, found);
        check("b2b_rd1_seen", found, 1);
        t1 = cyc;
        capture(10, -1, bits, ok, bc, rc);
        check("b2b_frame00", bits, 16'h0200);
        check("b2b_rd_count0", rc, 1);
        @(negedge clk);
        bad = !tx0 || rd0;
        @(negedge clk);
        check("b2b_rd2", rd0, 1);
        t2 = cyc;
        if (!tx0) bad = 1'b1;
        check("b2b_spacing", t2 - t1, 43);
        capture(10, -1, bits, ok, bc, rc);
        check("b2b_gap_high", bad || !ok, 0);
        check("b2b_frameff", bits, 16'h03FE);
        @(negedge clk);
        check("b2b_busy_end", busy0, 0);

        // even parity, 0x07 -> parity bit 1
        tx_en0 = 1'b0;
        sel    = 2'd1;
        tx_en1 = 1'b1;
        push(8'h07);
        wait_rd(20, found);
        check("even_rd_seen", found, 1);
        capture(11, -1, bits, ok, bc, rc);
        check("even_frame", bits, 16'h060E);
        check("even_par_bit", bits[9], 1);
        check("even_busy_cycles", bc, 46);
        tx_en1 = 1'b0;
        @(negedge clk);

        // odd parity with two stop bits, 0x07 -> parity bit 0, stop held 8 cycles
        sel    = 2'd2;
        tx_en2 = 1'b1;
        push(8'h07);
        wait_rd(20, found);
        check("odd_rd_seen", found, 1);
        capture(12, -1, bits, ok, bc, rc);
        check("odd_frame", bits, 16'h0C0E);
        check("odd_par_bit", bits[9], 0);
        check("odd_stop_hold", {ok, bits[11:10]}, 3'b111);
        check("odd_busy_cycles", bc, 50);
        tx_en2 = 1'b0;
        @(negedge clk);
        check("odd_busy_end", busy2, 0);

        // flow control: four words queued with tx_en low
        sel = 2'd0;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        push(8'h44);
        bad = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (any_rd || !tx0 || busy0) bad = 1'b1;
        end
        check("txen_low_hold", bad, 0);
        tx_en0 = 1'b1;
        wait_rd(20, found);
        check("txen_rd_seen", found, 1);
        capture(10, 4 * CPB + 1, bits, ok, bc, rc);
        check("txen_drop_frame", bits, 16'h0222);
        check("txen_drop_hold", ok, 1);
        bad = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (any_rd || !tx0 || busy0) bad = 1'b1;
        end
        check("txen_no_next_rd", bad, 0);
        tx_en0 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_rd(20, found);
            check("drain_rd_seen", found, 1);
            capture(10, -1, bits, ok, bc, rc);
            check("drain_frame", bits, drain_frame[k]);
            check("drain_word_hold", {ok, 8'h00} | {1'b0, drain_word[k]}, {1'b1, drain_word[k]});
        end
        @(negedge clk);

        // reset during data bit 5 of 0x3C
        push(8'h3C);
        wait_rd(20, found);
        check("mid_rd_seen", found, 1);
        repeat (2 + 5 * CPB + CPB) @(negedge clk);
        check("mid_bit5_level", tx0, 1);
        check("mid_busy", busy0, 1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_tx", tx0, 1);
        check("mid_rst_busy", busy0, 0);
        check("mid_rst_rd", rd0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bad = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (any_rd || !tx0 || busy0) bad = 1'b1;
        end
        check("post_rst_idle", bad, 0);

        // reset while the start bit is low must raise tx without a clock edge
        push(8'h3C);
        wait_rd(20, found);
        check("start_rd_seen", found, 1);
        repeat (3) @(negedge clk);
        check("start_bit_low", tx0, 0);
        #1 rst = 1'b1;
        #1;
        check("start_rst_tx", tx0, 1);
        check("start_rst_busy", busy0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
